// File: rtl/bin_window_filter.sv
// Purpose     : zero every FFT bin whose global index lies outside a per-frame window [lo, hi].
// Latency     : 1 cycle from input handshake to registered output.
// Backpressure: single output register; s_ready = !m_valid || m_ready, so a full stage stalls the input.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   s_valid/s_ready   input beat handshake
//   s_data            LANES bins per beat, lane k at [k*W +: W], lane 0 is the lowest bin
//   s_lo/s_hi         inclusive window bounds, sampled on beat 0 of each frame only
//   s_notch           (BWF_NOTCH_EN only) invert the keep decision for the frame, sampled on beat 0
//   m_valid/m_ready   output beat handshake
//   m_data            filtered beat, same lane packing
//   m_keep            per-lane keep mask
//   m_last            final beat of the frame
// Optional feature: define BWF_NOTCH_EN to add the s_notch port and notch mode.
module bin_window_filter #(
  parameter int W     = 8,
  parameter int LANES = 8,
  parameter int BEATS = 4,
  localparam int BIN_W = $clog2(LANES*BEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [LANES*W-1:0]   s_data,
  input  logic [BIN_W-1:0]     s_lo,
  input  logic [BIN_W-1:0]     s_hi,
`ifdef BWF_NOTCH_EN
  input  logic                 s_notch,
`endif
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [LANES*W-1:0]   m_data,
  output logic [LANES-1:0]     m_keep,
  output logic                 m_last
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS-1);

  logic [BEAT_W-1:0]   beat;
  logic [BIN_W-1:0]    lo_q;
  logic [BIN_W-1:0]    hi_q;
  logic                s_hs;
  logic                first_beat;
  logic [BIN_W-1:0]    lo_eff;
  logic [BIN_W-1:0]    hi_eff;
  logic                notch_eff;
  logic [BIN_W-1:0]    idx;
  logic                in_win;
  logic [LANES-1:0]    keep_nxt;
  logic [LANES*W-1:0]  data_nxt;

`ifdef BWF_NOTCH_EN
  logic                notch_q;
`endif

  assign s_ready    = !m_valid || m_ready;
  assign s_hs       = s_valid && s_ready;
  assign first_beat = (beat == '0);

  // Beat 0 uses the live bounds so the window applies to the frame's very
  // first beat; later beats use the copy captured on that beat.
  assign lo_eff = first_beat ? s_lo : lo_q;
  assign hi_eff = first_beat ? s_hi : hi_q;

`ifdef BWF_NOTCH_EN
  assign notch_eff = first_beat ? s_notch : notch_q;
`else
  assign notch_eff = 1'b0;
`endif

  // lo > hi makes in_win false for every lane, which yields an all-zero
  // frame in window mode and an all-pass frame in notch mode.
  always_comb begin
    idx      = '0;
    in_win   = 1'b0;
    keep_nxt = '0;
    data_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      idx         = BIN_W'(32'(beat) * LANES + k);
      in_win      = (idx >= lo_eff) && (idx <= hi_eff);
      keep_nxt[k] = in_win ^ notch_eff;
      data_nxt[k*W +: W] = keep_nxt[k] ? s_data[k*W +: W] : {W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      beat    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
`ifdef BWF_NOTCH_EN
      notch_q <= 1'b0;
`endif
    end else begin
      if (s_hs) begin
        m_valid <= 1'b1;
        m_data  <= data_nxt;
        m_keep  <= keep_nxt;
        m_last  <= (beat == LAST_BEAT);
        beat    <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        if (first_beat) begin
          lo_q    <= s_lo;
          hi_q    <= s_hi;
`ifdef BWF_NOTCH_EN
          notch_q <= s_notch;
`endif
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
